arb_request_ctrl: RTL and testbench

//  Requester-side counterpart of the 4-client priority/round-robin arbiter: queues job

---
 rtl/arb_pkg.sv | 26 ++
 rtl/arb_pending_counter.sv | 33 +++
 rtl/arb_request_ctrl.sv | 111 +++++++++++
 tb/tb_arb_request_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared state type and grant-decode helpers for the arbiter requester-side controller.
package arb_pkg;

   localparam int unsigned N_CLIENTS_DEF = 4;
   localparam int unsigned VEC_W         = 32;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } arb_state_e;

   function automatic logic is_onehot(input logic [VEC_W-1:0] v);
      return (v != '0) && ((v & (v - VEC_W'(1))) == '0);
   endfunction

   // Index of the lowest set bit; exact for one-hot vectors.
   function automatic logic [4:0] onehot_to_idx(input logic [VEC_W-1:0] v);
      logic [4:0] idx;
      idx = '0;
      for (int i = VEC_W - 1; i >= 0; i--) begin
         if (v[i]) idx = 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/arb_pending_counter.sv
// Per-client pending-job counter: saturates at all-ones, never underflows,
// simultaneous accepted increment and decrement hold the count.
module arb_pending_counter #(
   parameter int unsigned CNT_W = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic dec,
   output logic full,
   output logic nonzero
);

   logic [CNT_W-1:0] cnt;
   logic             inc_ok;
   logic             dec_ok;

   assign full    = (cnt == {CNT_W{1'b1}});
   assign nonzero = (cnt != '0);
   assign inc_ok  = inc & ~full;
   assign dec_ok  = dec & nonzero;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (inc_ok && !dec_ok) begin
         cnt <= cnt + CNT_W'(1);
      end else if (dec_ok && !inc_ok) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/arb_request_ctrl.sv
// Requester-side controller for the 4-client arbiter: queues jobs, requests, owns the
// resource for BURST_LEN cycles per grant. Optional grant checking via GNT_CHECK_EN.
module arb_request_ctrl
   import arb_pkg::*;
#(
   parameter int unsigned N_CLIENTS = N_CLIENTS_DEF,
   parameter int unsigned CNT_W     = 3,
   parameter int unsigned BURST_LEN = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_CLIENTS-1:0]         job_push,
   output logic [N_CLIENTS-1:0]         job_full,
   output logic [N_CLIENTS-1:0]         req,
   output logic                         arb_en,
   input  logic [N_CLIENTS-1:0]         gnt,
   output logic                         own_valid,
   output logic [$clog2(N_CLIENTS)-1:0] own_id,
   output logic                         own_last,
   output logic                         busy,
   output logic                         gnt_err
);

   localparam int unsigned ID_W   = $clog2(N_CLIENTS);
   localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

   arb_state_e           state;
   logic [BEAT_W-1:0]    beat;
   logic [N_CLIENTS-1:0] dec_vec;
   logic [N_CLIENTS-1:0] hit;
   logic [ID_W-1:0]      gnt_idx;
   logic                 accept;

   // The owner's job retires on the final beat of its burst.
   for (genvar i = 0; i < N_CLIENTS; i++) begin : g_client
      assign dec_vec[i] = own_last && (own_id == ID_W'(i));

      arb_pending_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk     (clk),
         .reset   (reset),
         .inc     (job_push[i]),
         .dec     (dec_vec[i]),
         .full    (job_full[i]),
         .nonzero (req[i])
      );
   end

   assign hit     = gnt & req;
   assign gnt_idx = ID_W'(onehot_to_idx(VEC_W'(hit)));
   assign busy    = (state == OWN) | (|req);

`ifdef GNT_CHECK_EN
   logic err_now;

   // Multi-bit grants or grants to idle clients are flagged and never accepted.
   assign err_now = (state == IDLE) && (gnt != '0) &&
                    (!is_onehot(VEC_W'(gnt)) || ((gnt & ~req) != '0));
   assign accept  = (hit != '0) && !err_now;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt_err <= 1'b0;
      end else if (err_now) begin
         gnt_err <= 1'b1;
      end
   end
`else
   assign accept  = (hit != '0);
   assign gnt_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         beat      <= '0;
         own_id    <= '0;
         own_valid <= 1'b0;
         own_last  <= 1'b0;
         arb_en    <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state     <= OWN;
                  beat      <= '0;
                  own_id    <= gnt_idx;
                  own_valid <= 1'b1;
                  own_last  <= (LAST_BEAT == '0);
                  arb_en    <= 1'b0;
               end
            end
            OWN: begin
               if (beat == LAST_BEAT) begin
                  state     <= IDLE;
                  own_valid <= 1'b0;
                  own_last  <= 1'b0;
                  arb_en    <= 1'b1;
               end else begin
                  beat     <= beat + BEAT_W'(1);
                  own_last <= ((beat + BEAT_W'(1)) == LAST_BEAT);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_arb_request_ctrl.sv
// Scoreboard bench for arb_request_ctrl with a behavioural fixed-priority arbiter.
module tb_arb_request_ctrl;

   localparam int N  = 4;
   localparam int BL = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] job_push = '0;
   logic [N-1:0] job_full;
   logic [N-1:0] req;
   logic [N-1:0] gnt;
   logic         arb_en;
   logic         own_valid;
   logic [1:0]   own_id;
   logic         own_last;
   logic         busy;
   logic         gnt_err;

   logic         hold = 1'b0;
   logic         ovr_en = 1'b0;
   logic [N-1:0] ovr_val = '0;

   int           checks = 0;
   int           errors = 0;
   logic [1:0]   exp_q[$];
   int           bursts = 0;
   int           last_gap = 0;
   int           b0;

   always #5 clk = ~clk;

   // Fixed-priority arbiter: lowest requesting index wins while enabled.
   always_comb begin
      if (ovr_en)                gnt = ovr_val;
      else if (arb_en && !hold)  gnt = req & (~req + 4'd1);
      else                       gnt = '0;
   end

   arb_request_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .job_push  (job_push),
      .job_full  (job_full),
      .req       (req),
      .arb_en    (arb_en),
      .gnt       (gnt),
      .own_valid (own_valid),
      .own_id    (own_id),
      .own_last  (own_last),
      .busy      (busy),
      .gnt_err   (gnt_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [N-1:0] m);
      job_push = m;
      tick();
      job_push = '0;
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk("idle_reached", 32'(busy), 32'd0);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_last(input int bound);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!own_last && n < bound);
      chk("own_last_seen", 32'(own_last), 32'd1);
   endtask

   // Monitor: tracks each burst and retires one scoreboard entry at its last beat.
   int         m_beat = 0;
   int         m_gap = 0;
   logic       m_in_burst = 1'b0;
   logic       m_seen = 1'b0;
   logic [1:0] m_id = '0;
   logic [1:0] m_exp;

   always @(negedge clk) begin
      if (reset) begin
         m_in_burst = 1'b0;
         m_beat     = 0;
         m_gap      = 0;
         m_seen     = 1'b0;
      end else if (own_valid) begin
         if (!m_in_burst) begin
            m_in_burst = 1'b1;
            m_beat     = 0;
            m_id       = own_id;
            chk("arb_en_low_in_own", 32'(arb_en), 32'd0);
            if (m_seen) begin
               last_gap = m_gap;
               chk("idle_gap_min", 32'(m_gap >= 1), 32'd1);
            end
         end else begin
            m_beat++;
            chk("own_id_stable", 32'(own_id), 32'(m_id));
         end
         chk("own_last_beat", 32'(own_last), 32'(m_beat == BL - 1));
         if (own_last || m_beat >= BL - 1) begin
            m_in_burst = 1'b0;
            m_seen     = 1'b1;
            m_gap      = 0;
            bursts++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL burst_unexpected: got owner %0d expected no burst", m_id);
            end else begin
               m_exp = exp_q.pop_front();
               chk("burst_owner", 32'(m_id), 32'(m_exp));
            end
         end
      end else begin
         if (m_in_burst) begin
            chk("burst_length", 32'(m_beat + 1), 32'(BL));
            m_in_burst = 1'b0;
         end
         m_gap++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", 32'(req), 32'd0);
      chk("rst_arb_en", 32'(arb_en), 32'd1);
      chk("rst_own_valid", 32'(own_valid), 32'd0);
      chk("rst_own_last", 32'(own_last), 32'd0);
      chk("rst_own_id", 32'(own_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_job_full", 32'(job_full), 32'd0);
      chk("rst_gnt_err", 32'(gnt_err), 32'd0);
      reset = 1'b0;
      tick();

      // 1: single job for client 2
      b0 = bursts;
      exp_q.push_back(2'd2);
      push(4'b0100);
      chk("t1_req_after_push", 32'(req), 32'h4);
      chk("t1_busy", 32'(busy), 32'd1);
      wait_last(20);
      tick();
      chk("t1_req_after_last", 32'(req), 32'd0);
      chk("t1_idle_after_last", 32'(own_valid), 32'd0);
      wait_idle(20);
      chk("t1_bursts", 32'(bursts - b0), 32'd1);

      // 2: clients 0 and 3 together, fixed priority
      b0 = bursts;
      exp_q.push_back(2'd0);
      exp_q.push_back(2'd3);
      push(4'b1001);
      wait_idle(60);
      chk("t2_gap", 32'(last_gap), 32'd1);
      chk("t2_bursts", 32'(bursts - b0), 32'd2);

      // 3: saturate client 1 with grants held off
      b0 = bursts;
      hold = 1'b1;
      for (int i = 0; i < 8; i++) begin
         push(4'b0010);
         if (i == 5) chk("t3_not_full_at_6", 32'(job_full), 32'd0);
         if (i == 6) chk("t3_full_at_7", 32'(job_full), 32'h2);
         if (i < 7) exp_q.push_back(2'd1);
      end
      chk("t3_full_after_8", 32'(job_full), 32'h2);
      chk("t3_req", 32'(req), 32'h2);
      hold = 1'b0;
      wait_idle(7 * (BL + 2) + 20);
      chk("t3_bursts", 32'(bursts - b0), 32'd7);
      chk("t3_full_cleared", 32'(job_full), 32'd0);

      // 4: push coincident with the owner's last beat
      b0 = bursts;
      exp_q.push_back(2'd1);
      exp_q.push_back(2'd1);
      push(4'b0010);
      wait_last(20);
      job_push = 4'b0010;
      @(posedge clk);
      #1;
      job_push = '0;
      chk("t4_req_held", 32'(req), 32'h2);
      chk("t4_idle_between", 32'(own_valid), 32'd0);
      wait_idle(40);
      chk("t4_bursts", 32'(bursts - b0), 32'd2);

      // 5: reset in the middle of a burst
      push(4'b0100);
      push(4'b0100);
      chk("t5_owning", 32'(own_valid), 32'd1);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("t5_own_valid", 32'(own_valid), 32'd0);
      chk("t5_req", 32'(req), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_arb_en", 32'(arb_en), 32'd1);
      chk("t5_own_last", 32'(own_last), 32'd0);
      exp_q.delete();
      @(negedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();

      // 6: multi-bit grant
      b0 = bursts;
      hold = 1'b1;
      exp_q.push_back(2'd0);
      exp_q.push_back(2'd1);
      push(4'b0011);
      ovr_en  = 1'b1;
      ovr_val = 4'b0011;
      tick();
      ovr_en  = 1'b0;
`ifdef GNT_CHECK_EN
      chk("t6_no_accept", 32'(own_valid), 32'd0);
      chk("t6_gnt_err", 32'(gnt_err), 32'd1);
`else
      chk("t6_accept", 32'(own_valid), 32'd1);
      chk("t6_own_id", 32'(own_id), 32'd0);
      chk("t6_gnt_err", 32'(gnt_err), 32'd0);
`endif
      hold = 1'b0;
      wait_idle(60);
`ifdef GNT_CHECK_EN
      chk("t6_gnt_err_sticky", 32'(gnt_err), 32'd1);
`else
      chk("t6_gnt_err_low", 32'(gnt_err), 32'd0);
`endif
      chk("t6_bursts", 32'(bursts - b0), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
